ex_muldiv_unit: RTL
===================

# ex_muldiv_unit

Iterative multiply/divide unit in the EX stage of the recognition CPU. It executes MULT/MULTU/DIV/DIVU over 33 cycles and holds the architectural HI/LO registers. The EX result mux reads Hi/Lo for MFHI/MFLO and forwards them into the WB ALU-result pipeline register. Busy drives the hazard unit, which stalls the front end for any mult/div/MFHI/MFLO/MTHI/MTLO while an operation is in flight.

## Interface
- No parameters; datapath fixed at 32 bits.
- Clock  in  1  system clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high; clears all state.
- Start  in  1  launch operation from Op/A/B; sampled on rising edge.
- Op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- A  in  32  multiplicand / dividend (rs).
- B  in  32  multiplier / divisor (rt).
- Flush  in  1  abort in-flight operation (branch/exception squash).
- HiWe  in  1  MTHI: write WData to Hi.
- LoWe  in  1  MTLO: write WData to Lo.
- WData  in  32  data for MTHI/MTLO.
- Busy  out  1  operation in flight (state != IDLE).
- Done  out  1  one-cycle pulse: Hi/Lo just updated by a completed operation.
- Hi  out  32  HI register (MULT high word / DIV remainder).
- Lo  out  32  LO register (MULT low word / DIV quotient).

## Operation
- States: IDLE, CALC, FIX. 5-bit iteration counter.
- IDLE + Start: latch Op; signed ops (01, 11) latch |A|, |B| and record result signs; unsigned ops latch A, B raw. Counter = 0 -> CALC.
- CALC: one radix-2 step per cycle. Multiply: shift-add into 64-bit accumulator. Divide: restoring shift-subtract, 32-bit partial remainder + quotient. After the 32nd step (counter 31) -> FIX.
- FIX: apply signs. MULT negates the 64-bit product if the operand signs differ. DIV negates the quotient if the signs differ; the remainder takes the sign of A. Write Hi/Lo, pulse Done -> IDLE.
- Results are bit-exact with MIPS32: quotient truncates toward zero.
- Divide by zero (B = 0, DIVU or DIV): normal latency, Lo = 32'hFFFFFFFF, Hi = A (raw input value).
- DIV 32'h80000000 / 32'hFFFFFFFF: Lo = 32'h80000000, Hi = 0.
- Priority each edge: Reset > Flush > Start > HiWe/LoWe > CALC/FIX progress.
- Flush: state -> IDLE, Hi/Lo unchanged, no Done. A Start in the same cycle is ignored.
- Start while Busy: abort the current operation and restart with the new operands (no Done for the aborted one).
- HiWe/LoWe while IDLE: write on that edge. While Busy: abort the operation, then perform the write. HiWe/LoWe together with Start: Start wins and the writes are dropped.
- Hi/Lo change only on a FIX completion, an MTHI/MTLO write, or Reset.

## Timing
- Reset values: Busy = 0, Done = 0, Hi = 0, Lo = 0, state IDLE, counter 0. Asserting Reset mid-operation clears these immediately, without waiting for a clock edge.
- Start sampled at edge k: Busy high from after edge k through the cycle before edge k+33 (33 cycles).
- Edge k+32: last CALC step, state -> FIX. Edge k+33: Hi/Lo written, Done = 1 for exactly one cycle, Busy = 0.
- Back-to-back: Start accepted at edge k+33 (when Done rises) begins the next operation. Done still pulses for the first.
- MTHI/MTLO latency: 1 edge. Hi/Lo outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- MULTU 32'hFFFFFFFF x 32'hFFFFFFFF -> after 33 cycles Hi = 32'hFFFFFFFE, Lo = 32'h00000001, Done a single 1-cycle pulse, Busy high for exactly 33 cycles.
- MULT -7 x 3 -> Hi = 32'hFFFFFFFF, Lo = 32'hFFFFFFEB. Then DIV -7 / 2 -> Lo = 32'hFFFFFFFD, Hi = 32'hFFFFFFFF.
- DIVU 100 / 0 -> Lo = 32'hFFFFFFFF, Hi = 100. DIV 32'h80000000 / -1 -> Lo = 32'h80000000, Hi = 0.
- Flush at cycle 10 of DIVU 1000/7 with preloaded Hi = 5, Lo = 9 -> Busy drops next edge, no Done, Hi/Lo remain 5/9. Repeat with Start asserted in the Flush cycle -> Start ignored.
- Start MULTU 3x4, restart with MULTU 5x6 at cycle 20 -> only one Done, 33 cycles after the restart, Lo = 30, Hi = 0. MTLO 32'h1234 while IDLE -> Lo = 32'h1234 next edge.
- Reset asserted asynchronously mid-CALC with Hi/Lo nonzero -> Busy, Done, Hi, Lo all 0 immediately. After release, a new MULTU 2x2 gives Lo = 4 on schedule.

Source files
------------

// File: rtl/ex_muldiv_unit_if.sv
// ex_muldiv_unit_if
//   Bundles the EX-stage command/result signals of the iterative multiply/divide
//   unit.
//   master : EX control side. Drives Start/Op/A/B/Flush/HiWe/LoWe/WData and
//            receives Busy/Done/Hi/Lo.
//   slave  : the multiply/divide unit itself.
interface ex_muldiv_unit_if;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        Flush;
  logic        HiWe;
  logic        LoWe;
  logic [31:0] WData;
  logic        Busy;
  logic        Done;
  logic [31:0] Hi;
  logic [31:0] Lo;

  modport master (
    output Start, Op, A, B, Flush, HiWe, LoWe, WData,
    input  Busy, Done, Hi, Lo
  );

  modport slave (
    input  Start, Op, A, B, Flush, HiWe, LoWe, WData,
    output Busy, Done, Hi, Lo
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit
//   Iterative 32-bit MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO
//   registers. An operation takes 33 cycles: 32 radix-2 steps followed by a sign
//   fix-up cycle that writes Hi/Lo and pulses Done.
//   Ports:
//     Clock  : system clock, rising edge.
//     Reset  : asynchronous, active-high; clears all state.
//     io_md  : command/result bundle (slave side):
//              Start/Op/A/B launch, Flush abort, HiWe/LoWe/WData MTHI/MTLO,
//              Busy/Done/Hi/Lo status and results (all registered).
//
//   state  | meaning
//   -------+---------------------------------------------------------
//   S_IDLE | no operation in flight, Hi/Lo hold
//   S_CALC | one shift-add / shift-subtract step per cycle, 32 steps
//   S_FIX  | apply result signs, write Hi/Lo, pulse Done
module ex_muldiv_unit (
  input  logic             Clock,
  input  logic             Reset,
  ex_muldiv_unit_if.slave  io_md
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic        r_is_div;
  logic [31:0] r_opnd;     // multiplicand (mult) or divisor (div), magnitude
  logic [63:0] r_acc;      // mult: {partial product, multiplier}; div: {remainder, quotient}
  logic        r_neg_res;  // negate product / quotient in FIX
  logic        r_neg_rem;  // negate remainder in FIX
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_busy;
  logic        r_done;

  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_next;
  logic [32:0] w_div_trial;
  logic [63:0] w_div_next;
  logic [63:0] w_prod;
  logic [31:0] w_fix_hi;
  logic [31:0] w_fix_lo;
  logic        w_mt;
  logic        w_fix_commit;

  assign w_abs_a = (io_md.Op[0] && io_md.A[31]) ? (~io_md.A + 32'd1) : io_md.A;
  assign w_abs_b = (io_md.Op[0] && io_md.B[31]) ? (~io_md.B + 32'd1) : io_md.B;

  assign w_mt = io_md.HiWe | io_md.LoWe;

  // A Start landing on the FIX edge still completes the finishing operation;
  // an MTHI/MTLO alone on that edge aborts it instead.
  assign w_fix_commit = (r_state == S_FIX) && (io_md.Start || !w_mt);

  always_comb begin
    w_mul_sum   = {1'b0, r_acc[63:32]} + {1'b0, r_opnd};
    w_mul_next  = r_acc[0] ? {w_mul_sum, r_acc[31:1]}
                           : {1'b0, r_acc[63:32], r_acc[31:1]};
    // Partial remainder stays below the divisor, so a 33-bit trial is enough.
    w_div_trial = {r_acc[63:32], r_acc[31]} - {1'b0, r_opnd};
    w_div_next  = w_div_trial[32] ? {r_acc[62:0], 1'b0}
                                  : {w_div_trial[31:0], r_acc[30:0], 1'b1};
    w_prod      = r_neg_res ? (~r_acc + 64'd1) : r_acc;
    w_fix_hi    = w_prod[63:32];
    w_fix_lo    = w_prod[31:0];
    if (r_is_div) begin
      w_fix_lo = r_neg_res ? (~r_acc[31:0] + 32'd1)  : r_acc[31:0];
      w_fix_hi = r_neg_rem ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_is_div  <= 1'b0;
      r_opnd    <= '0;
      r_acc     <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (io_md.Flush) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        if (w_fix_commit) begin
          r_hi   <= w_fix_hi;
          r_lo   <= w_fix_lo;
          r_done <= 1'b1;
        end
        if (io_md.Start) begin
          r_state  <= S_CALC;
          r_busy   <= 1'b1;
          r_cnt    <= '0;
          r_is_div <= io_md.Op[1];
          // Divide by zero keeps the all-ones quotient unsigned; the remainder
          // path naturally reproduces A.
          r_neg_res <= io_md.Op[0] & (io_md.A[31] ^ io_md.B[31]) & (|io_md.B);
          r_neg_rem <= io_md.Op[0] & io_md.A[31];
          if (io_md.Op[1]) begin
            r_opnd <= w_abs_b;
            r_acc  <= {32'd0, w_abs_a};
          end else begin
            r_opnd <= w_abs_a;
            r_acc  <= {32'd0, w_abs_b};
          end
        end else if (w_mt) begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          if (io_md.HiWe) r_hi <= io_md.WData;
          if (io_md.LoWe) r_lo <= io_md.WData;
        end else begin
          case (r_state)
            S_CALC: begin
              r_acc <= r_is_div ? w_div_next : w_mul_next;
              r_cnt <= r_cnt + 5'd1;
              if (r_cnt == 5'd31) r_state <= S_FIX;
            end
            S_FIX: begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
            default: begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign io_md.Busy = r_busy;
  assign io_md.Done = r_done;
  assign io_md.Hi   = r_hi;
  assign io_md.Lo   = r_lo;

endmodule
